// File: rtl/imem_loader.sv
// imem_loader: packs a little-endian byte stream into instruction-memory words, verifies a trailing XOR checksum and gates core reset
module imem_loader #(
  parameter int ADDR_W    = 5,
  parameter int NUM_WORDS = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              core_hold
);
  typedef enum logic [2:0] {IDLE, RECV, WRITE, CHECK, DONE, ERR} state_t;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_WORDS - 1);
  state_t            r_state;
  logic [1:0]        r_idx;
  logic [ADDR_W-1:0] r_widx;
  logic [7:0]        r_csum;
  logic [23:0]       r_word;
  logic              r_ck_got;
  logic              r_ck_ok;
  logic              w_acc;
  assign w_acc = byte_valid & byte_ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_widx     <= '0;
      r_csum     <= '0;
      r_word     <= '0;
      r_ck_got   <= 1'b0;
      r_ck_ok    <= 1'b0;
      byte_ready <= 1'b0;
      we         <= 1'b0;
      waddr      <= '0;
      wdata      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      core_hold  <= 1'b1;
    end else begin
      we <= 1'b0;
      case (r_state)
        IDLE, DONE, ERR: if (start) begin
          r_state    <= RECV;
          r_idx      <= '0;
          r_widx     <= '0;
          r_csum     <= '0;
          byte_ready <= 1'b1;
          busy       <= 1'b1;
          done       <= 1'b0;
          err        <= 1'b0;
          core_hold  <= 1'b1;
        end
        RECV: if (w_acc) begin
          r_csum <= r_csum ^ byte_data;
          r_idx  <= r_idx + 2'd1;
          if (r_idx == 2'd3) begin
            wdata      <= {byte_data, r_word};
            waddr      <= r_widx;
            we         <= 1'b1;
            byte_ready <= 1'b0;
            r_state    <= WRITE;
          end else begin
            r_word[8*r_idx +: 8] <= byte_data;
          end
        end
        WRITE: begin
          byte_ready <= 1'b1;
          r_ck_got   <= 1'b0;
          r_state    <= (r_widx == LAST) ? CHECK : RECV;
          r_widx     <= (r_widx == LAST) ? r_widx : r_widx + 1'b1;
        end
        CHECK: if (r_ck_got) begin
          // the verdict is published one cycle after the checksum byte lands
          r_state   <= r_ck_ok ? DONE : ERR;
          busy      <= 1'b0;
          done      <= r_ck_ok;
          err       <= ~r_ck_ok;
          core_hold <= ~r_ck_ok;
        end else if (w_acc) begin
          r_ck_got   <= 1'b1;
          r_ck_ok    <= (byte_data == r_csum);
          byte_ready <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scoreboard bench driving a 2-word and a 32-word loader from a shared byte stream
module tb_imem_loader;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start2 = 1'b0, start32 = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = '0;
  logic        rdy2, we2, busy2, done2, err2, hold2;
  logic        rdy32, we32, busy32, done32, err32, hold32;
  logic [4:0]  waddr2, waddr32;
  logic [31:0] wdata2, wdata32;
  logic [36:0] q2[$], q32[$];
  logic [36:0] e2, e32;
  logic [7:0]  s1[8];
  int          n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(5), .NUM_WORDS(2)) d2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(rdy2), .we(we2), .waddr(waddr2), .wdata(wdata2),
    .busy(busy2), .done(done2), .err(err2), .core_hold(hold2));

  imem_loader d32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(rdy32), .we(we32), .waddr(waddr32), .wdata(wdata32),
    .busy(busy32), .done(done32), .err(err32), .core_hold(hold32));

  always @(negedge clk) begin
    if (we2) begin
      n_chk++;
      if (q2.size() == 0) $display("FAIL w2_unexpected got %0d:%h want none", waddr2, wdata2);
      else begin
        e2 = q2.pop_front();
        if ({waddr2, wdata2} == e2) n_pass++;
        else $display("FAIL w2_write got %0d:%h want %0d:%h", waddr2, wdata2, e2[36:32], e2[31:0]);
      end
      n_chk++;
      if (!rdy2) n_pass++; else $display("FAIL w2_overlap got ready=1 want 0");
    end
    if (we32) begin
      n_chk++;
      if (q32.size() == 0) $display("FAIL w32_unexpected got %0d:%h want none", waddr32, wdata32);
      else begin
        e32 = q32.pop_front();
        if ({waddr32, wdata32} == e32) n_pass++;
        else $display("FAIL w32_write got %0d:%h want %0d:%h", waddr32, wdata32, e32[36:32], e32[31:0]);
      end
      n_chk++;
      if (!rdy32) n_pass++; else $display("FAIL w32_overlap got ready=1 want 0");
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s got %h want %h", name, got, want);
  endtask

  task automatic send(input bit sel, input logic [7:0] b, input int gap);
    int t = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (!(sel ? rdy32 : rdy2) && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      n_chk++;
      $display("FAIL send_timeout got ready=0 want 1");
    end
    @(negedge clk);
    byte_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic pulse2();
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
  endtask

  task automatic push2();
    q2.push_back({5'd0, 32'h01234567});
    q2.push_back({5'd1, 32'h89ABCDEF});
  endtask

  task automatic status2(input string name, input logic d, input logic e, input logic h);
    chk({name, "_done"}, 32'(done2), 32'(d));
    chk({name, "_err"},  32'(err2),  32'(e));
    chk({name, "_hold"}, 32'(hold2), 32'(h));
    chk({name, "_busy"}, 32'(busy2), 32'd0);
  endtask

  task automatic load2(input string name, input logic [7:0] cs, input int gap, input logic ok);
    pulse2();
    push2();
    for (int i = 0; i < 8; i++) send(1'b0, s1[i], gap);
    send(1'b0, cs, 0);
    chk({name, "_busy_m"}, 32'(busy2), 32'd1);
    @(negedge clk);
    status2(name, ok, ~ok, ~ok);
    chk({name, "_q"}, 32'(q2.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    s1 = '{8'h67, 8'h45, 8'h23, 8'h01, 8'hEF, 8'hCD, 8'hAB, 8'h89};
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(rdy2), 32'd0);
    chk("rst_we",    32'(we2),  32'd0);
    chk("rst_hold",  32'(hold2), 32'd1);
    chk("rst_wdata", wdata2, 32'd0);
    chk("rst_hold32", 32'(hold32), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    load2("t1", 8'h00, 0, 1'b1);
    load2("t2", 8'h5A, 0, 1'b0);
    load2("t3", 8'h00, 2, 1'b1);
    // test 4: reset after six bytes, only word 0 has been written
    pulse2();
    q2.push_back({5'd0, 32'h01234567});
    for (int i = 0; i < 6; i++) send(1'b0, s1[i], 0);
    rst_n = 1'b0;
    #1;
    chk("t4_ready", 32'(rdy2), 32'd0);
    chk("t4_busy",  32'(busy2), 32'd0);
    chk("t4_done",  32'(done2), 32'd0);
    chk("t4_err",   32'(err2), 32'd0);
    chk("t4_hold",  32'(hold2), 32'd1);
    chk("t4_waddr", 32'(waddr2), 32'd0);
    chk("t4_wdata", wdata2, 32'd0);
    chk("t4_q",     32'(q2.size()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    load2("t4b", 8'h00, 0, 1'b1);
    // test 5: start during RECV is ignored, start in DONE restarts
    pulse2();
    push2();
    send(1'b0, s1[0], 0);
    send(1'b0, s1[1], 0);
    pulse2();
    for (int i = 2; i < 8; i++) send(1'b0, s1[i], 0);
    send(1'b0, 8'h00, 0);
    @(negedge clk);
    status2("t5", 1'b1, 1'b0, 1'b0);
    pulse2();
    chk("t5r_busy", 32'(busy2), 32'd1);
    chk("t5r_done", 32'(done2), 32'd0);
    chk("t5r_hold", 32'(hold2), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    // test 6: full 32-word load, word k = k, checksum 00
    start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    for (int k = 0; k < 32; k++) q32.push_back({5'(k), 32'(k)});
    for (int k = 0; k < 32; k++) begin
      send(1'b1, 8'(k), 0);
      for (int j = 0; j < 3; j++) send(1'b1, 8'h00, 0);
    end
    send(1'b1, 8'h00, 0);
    @(negedge clk);
    chk("t6_done", 32'(done32), 32'd1);
    chk("t6_err",  32'(err32), 32'd0);
    chk("t6_hold", 32'(hold32), 32'd0);
    chk("t6_q",    32'(q32.size()), 32'd0);
    chk("t6_idle2", 32'(busy2), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
